// File: rtl/balanced_rand_gen.sv
// LFSR-driven symbol generator that caps how often each symbol may be issued
// within a window of draws, with one draw per rising edge of the request level.
module balanced_rand_gen #(
    parameter int                LFSR_W  = 8,
    parameter logic [LFSR_W-1:0] TAPS    = 8'hB8,
    parameter int                SYMBOLS = 3,
    parameter int                OUT_W   = 2,
    parameter int                QUOTA   = 3,
    parameter int                WINDOW  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              req,
    output logic              rand_valid,
    output logic [OUT_W-1:0]  rand_out,
    output logic              window_done
);

    localparam int CNT_W  = $clog2(QUOTA + 1);
    localparam int DRAW_W = $clog2(WINDOW + 1);
    localparam int IW     = OUT_W + 1;

    localparam logic [CNT_W-1:0]  QUOTA_C  = CNT_W'(QUOTA);
    localparam logic [DRAW_W-1:0] WINDOW_C = DRAW_W'(WINDOW);
    localparam logic [OUT_W-1:0]  SYM_LAST = OUT_W'(SYMBOLS - 1);
    localparam logic [IW-1:0]     SYM_C    = IW'(SYMBOLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [LFSR_W-1:0]  w_lfsr_next;
    logic [OUT_W-1:0]   r_rr;
    logic [OUT_W-1:0]   r_out;
    logic [CNT_W-1:0]   r_count [SYMBOLS];
    logic [DRAW_W-1:0]  r_draw_cnt;
    logic [OUT_W-1:0]   w_cand;
    logic [OUT_W-1:0]   w_pick;
    logic [IW-1:0]      w_idx;
    logic               w_found;
    logic               w_draw;
    logic               w_window_end;
    logic [SYMBOLS-1:0] w_full;

    genvar gi;
    generate
        for (gi = 0; gi < SYMBOLS; gi++) begin : g_full
            assign w_full[gi] = (r_count[gi] == QUOTA_C);
        end
    endgenerate

    // A zero seed would freeze the LFSR, so it is replaced by all-ones.
    always_comb begin
        w_lfsr_next = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
        if (seed_load) begin
            w_lfsr_next = (seed == '0) ? '1 : seed;
        end
    end

    always_comb begin
        w_cand = r_lfsr[OUT_W-1:0];
        if ({1'b0, w_cand} >= SYM_C) begin
            w_cand = r_rr;
        end
    end

    // Walk forward (with wrap) from the candidate to the first symbol under quota.
    always_comb begin
        w_pick  = w_cand;
        w_found = !w_full[w_cand];
        w_idx   = '0;
        for (int k = 1; k < SYMBOLS; k++) begin
            w_idx = {1'b0, w_cand} + IW'(k);
            if (w_idx >= SYM_C) begin
                w_idx = w_idx - SYM_C;
            end
            if (!w_found && !w_full[w_idx[OUT_W-1:0]]) begin
                w_pick  = w_idx[OUT_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_draw       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_next = S_ISSUE;
                    w_draw       = 1'b1;
                end
            end
            S_ISSUE:    w_state_next = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!req) begin
                    w_state_next = S_IDLE;
                end
            end
            default:    w_state_next = S_IDLE;
        endcase
    end

    assign w_window_end = (r_state == S_ISSUE) && (r_draw_cnt == WINDOW_C);
    assign rand_valid   = (r_state == S_ISSUE);
    assign window_done  = w_window_end;
    assign rand_out     = r_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= '1;
            r_rr       <= '0;
            r_out      <= '0;
            r_draw_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_rr    <= (r_rr == SYM_LAST) ? '0 : r_rr + 1'b1;
            if (w_draw) begin
                r_out      <= w_pick;
                r_draw_cnt <= r_draw_cnt + 1'b1;
            end else if (w_window_end) begin
                r_draw_cnt <= '0;
            end
        end
    end

    // Draw and window clear never coincide: they happen in different states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYMBOLS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYMBOLS; i++) begin
                if (w_window_end) begin
                    r_count[i] <= '0;
                end else if (w_draw && (w_pick == OUT_W'(i))) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_balanced_rand_gen.sv
// Directed bench for balanced_rand_gen: reset, window balance, edge-qualified
// requests, reseeding, simultaneous seed/request and mid-handshake reset.
module tb_balanced_rand_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       seed_load;
    logic [7:0] seed;
    logic       req;
    logic       rand_valid;
    logic [1:0] rand_out;
    logic       window_done;

    int n_err = 0;
    int n_chk = 0;

    // Shadow state: LFSR, rotating counter, handshake phase, quota counts.
    logic [7:0] m_lfsr;
    int         m_rr;
    int         m_state;
    int         m_out;
    int         m_draws;
    int         m_cnt [3];

    balanced_rand_gen dut (
        .clk         (clk),
        .reset       (reset),
        .seed_load   (seed_load),
        .seed        (seed),
        .req         (req),
        .rand_valid  (rand_valid),
        .rand_out    (rand_out),
        .window_done (window_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = 8'hFF;
        m_rr    = 0;
        m_state = 0;
        m_out   = 0;
        m_draws = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    function automatic int pick(input logic [7:0] l, input int rr);
        int c;
        c = int'(l[1:0]);
        if (c >= 3) c = rr;
        for (int n = 0; n < 3; n++) begin
            if (m_cnt[c] < 3) return c;
            c = (c + 1) % 3;
        end
        return -1;
    endfunction

    task automatic tick();
        if (reset) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (req) begin
                    m_out = pick(m_lfsr, m_rr);
                    m_cnt[m_out]++;
                    m_draws++;
                    m_state = 1;
                end
                1: begin
                    if (m_draws == 9) begin
                        m_draws = 0;
                        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
                    end
                    m_state = 2;
                end
                default: if (!req) m_state = 0;
            endcase
            if (seed_load) m_lfsr = (seed == 8'h00) ? 8'hFF : seed;
            else           m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            m_rr = (m_rr + 1) % 3;
        end
        @(posedge clk);
        #1;
        chk("rand_valid", 32'(rand_valid), 32'(m_state == 1));
        chk("window_done", 32'(window_done), 32'(m_state == 1 && m_draws == 9));
        chk("rand_out", 32'(rand_out), 32'(m_out));
        chk("lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));
    endtask

    task automatic do_draw(output int sym, output bit wd);
        req = 1'b1;
        tick();
        sym = int'(rand_out);
        wd  = window_done;
        $display("draw: sym=%0d rand_valid=%0b window_done=%0b", rand_out, rand_valid, window_done);
        req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int  s;
        bit  wd;
        int  hist [3];
        int  wd_cnt;
        int  nv;
        int  exp_sym;

        reset     = 1'b1;
        req       = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // 1. reset state
        chk("rst_rand_out", 32'(rand_out), 32'd0);
        chk("rst_rand_valid", 32'(rand_valid), 32'd0);
        chk("rst_window_done", 32'(window_done), 32'd0);
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'h0000_00FF);
        chk("rst_rr", 32'(dut.r_rr), 32'd0);

        // 2. full window from reset; first three draws worked out by hand: 0, 0, 2
        for (int i = 0; i < 3; i++) hist[i] = 0;
        wd_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            do_draw(s, wd);
            hist[s]++;
            if (wd) wd_cnt++;
            if (i == 0) chk("draw1_hand", 32'(s), 32'd0);
            if (i == 1) chk("draw2_hand", 32'(s), 32'd0);
            if (i == 2) chk("draw3_hand", 32'(s), 32'd2);
            if (i == 8) chk("wd_on_9th", 32'(wd), 32'd1);
        end
        chk("win_hist0", 32'(hist[0]), 32'd3);
        chk("win_hist1", 32'(hist[1]), 32'd3);
        chk("win_hist2", 32'(hist[2]), 32'd3);
        chk("win_wd_count", 32'(wd_cnt), 32'd1);
        chk("win_draw_cnt_clr", 32'(dut.r_draw_cnt), 32'd0);
        chk("win_cnt0_clr", 32'(dut.r_count[0]), 32'd0);
        chk("win_cnt1_clr", 32'(dut.r_count[1]), 32'd0);
        chk("win_cnt2_clr", 32'(dut.r_count[2]), 32'd0);

        // 3. held request gives one draw; a fresh rising edge gives another
        req = 1'b1;
        tick();
        chk("held_first_valid", 32'(rand_valid), 32'd1);
        nv = 1;
        repeat (19) begin
            tick();
            if (rand_valid) nv++;
        end
        chk("held_one_pulse", 32'(nv), 32'd1);
        req = 1'b0;
        tick();
        tick();
        req = 1'b1;
        tick();
        chk("rerise_valid", 32'(rand_valid), 32'd1);
        $display("draw: sym=%0d rand_valid=%0b window_done=%0b", rand_out, rand_valid, window_done);
        req = 1'b0;
        tick();
        tick();

        // 4. reseeding: zero seed loads all-ones; 5A steps to B4
        seed_load = 1'b1;
        seed      = 8'h00;
        tick();
        chk("seed0_lfsr", 32'(dut.r_lfsr), 32'h0000_00FF);
        seed = 8'h5A;
        tick();
        chk("seed5a_lfsr", 32'(dut.r_lfsr), 32'h0000_005A);
        seed_load = 1'b0;
        tick();
        chk("seed5a_next", 32'(dut.r_lfsr), 32'h0000_00B4);

        // 6. seed load and request on the same edge: draw uses the old LFSR
        seed      = 8'h3C;
        seed_load = 1'b1;
        req       = 1'b1;
        exp_sym   = pick(m_lfsr, m_rr);
        tick();
        chk("simul_sym", 32'(rand_out), 32'(exp_sym));
        chk("simul_lfsr", 32'(dut.r_lfsr), 32'h0000_003C);
        $display("draw: sym=%0d rand_valid=%0b window_done=%0b", rand_out, rand_valid, window_done);
        seed_load = 1'b0;
        req       = 1'b0;
        tick();
        tick();

        // 5. reset in the middle of the fifth draw's ISSUE cycle, then a clean window
        for (int i = 0; i < 4; i++) do_draw(s, wd);
        req = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(rand_valid), 32'd0);
        chk("midrst_rand_out", 32'(rand_out), 32'd0);
        chk("midrst_lfsr", 32'(dut.r_lfsr), 32'h0000_00FF);
        chk("midrst_draw_cnt", 32'(dut.r_draw_cnt), 32'd0);
        model_reset();
        req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 0;
        wd_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            do_draw(s, wd);
            hist[s]++;
            if (wd) wd_cnt++;
            if (i == 8) chk("post_rst_wd_on_9th", 32'(wd), 32'd1);
        end
        chk("post_rst_hist0", 32'(hist[0]), 32'd3);
        chk("post_rst_hist1", 32'(hist[1]), 32'd3);
        chk("post_rst_hist2", 32'(hist[2]), 32'd3);
        chk("post_rst_wd_count", 32'(wd_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
